collision_event_gen: RTL
========================

// Module: collision_event_gen
// PURPOSE
//  Turns per-pixel drawing-request overlaps from the VGA scan into clean, once-per-frame,
//  single-cycle collision pulses for the game controller.
//  Sits between the object drawers (smiley, bottom border, obstacles) and game_controller.
//  Guarantees one event per frame, fixed priority, and no repeated obstacle hits while the
//  ball is still overlapping.
// PARAMETERS
//  HOLDOFF_FRAMES  4  frames during which obstacle events are suppressed after an emitted obstacle event
//  HOLDOFF_W       $clog2(HOLDOFF_FRAMES+1)  holdoff counter width (derived, do not override)
// PORTS
//  clk                          in   1  system clock; single clock domain
//  resetN                       in   1  asynchronous reset, active-low
//  startOfFrame                 in   1  1-cycle pulse on the first pixel of each frame
//  pause                        in   1  from game_controller; 1 = game not running
//  smileyDrawingRequest         in   1  smiley pixel active this cycle
//  borderBottomDrawingRequest   in   1  bottom-border pixel active this cycle
//  obstacleDrawingRequest       in   1  any obstacle pixel active this cycle
//  obstacleGood                 in   1  type of the obstacle at this pixel (1 = good, 0 = bad); valid with obstacleDrawingRequest
//  collisionSmileyBorderBottom  out  1  1-cycle pulse: ball touched bottom border last frame
//  collisionSmileyObstacle      out  1  1-cycle pulse: ball touched an obstacle last frame
//  collisionSmileyObstacleGood  out  1  qualifies collisionSmileyObstacle: good obstacle
//  collisionSmileyObstacleBad   out  1  qualifies collisionSmileyObstacle: bad obstacle
// BEHAVIOUR
//  - Reset: all outputs 0, sticky flags 0, holdoff counter 0.
//  - Sticky per-frame flags, set on any cycle with smileyDrawingRequest=1:
//      hitBottom <= smiley & borderBottom
//      hitGood   <= smiley & obstacle & obstacleGood
//      hitBad    <= smiley & obstacle & ~obstacleGood
//  - Frame close on startOfFrame:
//      - Flags are evaluated, then cleared.
//      - Overlaps sampled in the startOfFrame cycle count toward the NEW frame.
//  - Outputs are registered and pulse for exactly 1 cycle, the cycle after startOfFrame.
//    They are 0 at all other times.
//  - Priority at frame close:
//      1. If hitBottom: emit BorderBottom only. Obstacle outputs stay 0 that frame.
//      2. Else if hitGood and not held off: emit Obstacle and ObstacleGood.
//         Good wins over a same-frame Bad.
//      3. Else if hitBad and not held off: emit Obstacle and ObstacleBad.
//  - Invariants:
//      - Good and Bad are never high together.
//      - Obstacle is high exactly when Good or Bad is high.
//      - BorderBottom is never high together with Obstacle.
//  - Holdoff counter (see CONFIGURATION):
//      - Loaded with HOLDOFF_FRAMES when an obstacle event is emitted.
//      - Otherwise decrements by 1 at each startOfFrame while nonzero; saturates at 0.
//      - Obstacle events are suppressed while it is nonzero.
//      - Bottom events are never held off.
//  - pause=1:
//      - Sticky flags are held cleared and the holdoff counter is forced to 0.
//      - Outputs are forced to 0, including in the cycle after a startOfFrame.
//      - pause falling mid-frame: only overlaps from the following cycles are accumulated.
//  - pause rising in the same cycle as startOfFrame: pause wins; no event is emitted.
//  - resetN asserted mid-frame clears everything immediately (async). No event fires for the
//    partial frame.
// CONFIGURATION
//  COLLISION_HOLDOFF_EN
//  - Defined: holdoff counter is instantiated as described in BEHAVIOUR.
//  - Undefined: no counter. Every frame with an obstacle overlap emits an event (subject to the
//    priority rules), and HOLDOFF_FRAMES is ignored.
// STRUCTURE
//  - Package defines:
//      - typedef struct packed {logic bottom; logic good; logic bad;} collision_flags_t
//      - localparam COLLISION_HOLDOFF_FRAMES = 4, used as the top-level override value.
//  - Sub-module collision_holdoff_timer: load/decrement/zero-detect counter with inputs
//    clk, resetN, clear, load, tick and output active. Compiled only under COLLISION_HOLDOFF_EN.
//  - Top: flag accumulator, priority encoder, output register.
// TESTING
//  1. Reset, pause=0; smiley & borderBottom overlap at 3 pixels of frame N
//     -> after next startOfFrame, BorderBottom=1 for exactly 1 cycle; others 0.
//  2. Same frame has a bottom overlap and a good-obstacle overlap
//     -> only BorderBottom pulses; Obstacle, Good and Bad stay 0.
//  3. Same frame has good and bad overlaps
//     -> Obstacle=1 and Good=1, Bad=0, single cycle.
//  4. HOLDOFF_EN, HOLDOFF_FRAMES=4; good overlap in frames 0..6
//     -> pulses at closes of frames 0 and 5 only. Without the macro, pulses at all 7 closes.
//  5. pause=1 with overlaps in every frame for 3 frames -> no outputs.
//     Drop pause mid-frame with an overlap after the drop -> pulse at that frame close.
//  6. Overlap only in the startOfFrame cycle -> no pulse at this close; pulse at the next close.
//     Assert resetN=0 mid-frame after an overlap -> no pulse at the next close.

Source files
------------

// File: rtl/collision_event_gen_pkg.sv
// Shared types and constants for the collision event generator.
// Build option: COLLISION_HOLDOFF_EN enables the obstacle holdoff timer.
package collision_event_gen_pkg;

    // Per-frame sticky overlap flags.
    typedef struct packed {
        logic bottom;
        logic good;
        logic bad;
    } collision_flags_t;

    // Holdoff length in frames used by the top-level instance.
    localparam int COLLISION_HOLDOFF_FRAMES = 4;

endpackage

// File: rtl/collision_event_gen_holdoff_timer.sv
// Obstacle holdoff counter: load on an emitted obstacle event, count down one
// step per frame close, report active while nonzero.
// Compiled only when COLLISION_HOLDOFF_EN is defined.
`ifdef COLLISION_HOLDOFF_EN
module collision_holdoff_timer #(
    parameter int FRAMES = 4,
    parameter int W      = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic load,
    input  logic tick,
    output logic active
);

    logic [W-1:0] cnt_reg;

    // Clear has priority, then load, then saturating decrement on tick.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= W'(FRAMES);
        end else if (tick && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign active = (cnt_reg != '0);

endmodule
`endif

// File: rtl/collision_event_gen.sv
// Collision event generator: accumulates smiley overlaps over a frame and emits
// one prioritised, single-cycle collision pulse after each startOfFrame.
// Build option: COLLISION_HOLDOFF_EN adds the obstacle holdoff timer.
module collision_event_gen
    import collision_event_gen_pkg::*;
#(
    parameter  int HOLDOFF_FRAMES = COLLISION_HOLDOFF_FRAMES,
    localparam int HOLDOFF_W      = $clog2(HOLDOFF_FRAMES + 1)
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic pause,
    input  logic smileyDrawingRequest,
    input  logic borderBottomDrawingRequest,
    input  logic obstacleDrawingRequest,
    input  logic obstacleGood,
    output logic collisionSmileyBorderBottom,
    output logic collisionSmileyObstacle,
    output logic collisionSmileyObstacleGood,
    output logic collisionSmileyObstacleBad
);

    collision_flags_t overlap;
    collision_flags_t flags_reg;
    collision_flags_t flags_next;
    logic             frame_close;
    logic             emit_bottom;
    logic             emit_good;
    logic             emit_bad;
    logic             holdoff_active;

    // Overlap detection, priority encoding and next-flag computation.
    always_comb begin
        overlap.bottom = smileyDrawingRequest & borderBottomDrawingRequest;
        overlap.good   = smileyDrawingRequest & obstacleDrawingRequest & obstacleGood;
        overlap.bad    = smileyDrawingRequest & obstacleDrawingRequest & ~obstacleGood;

        frame_close = startOfFrame & ~pause;

        // Bottom beats everything; good beats bad; obstacle events obey holdoff.
        emit_bottom = flags_reg.bottom;
        emit_good   = ~flags_reg.bottom & flags_reg.good & ~holdoff_active;
        emit_bad    = ~flags_reg.bottom & ~flags_reg.good & flags_reg.bad & ~holdoff_active;

        // The startOfFrame cycle's own overlaps seed the new frame.
        if (pause) begin
            flags_next = '0;
        end else if (startOfFrame) begin
            flags_next = overlap;
        end else begin
            flags_next = flags_reg | overlap;
        end
    end

`ifdef COLLISION_HOLDOFF_EN
    collision_holdoff_timer #(
        .FRAMES (HOLDOFF_FRAMES),
        .W      (HOLDOFF_W)
    ) u_holdoff (
        .clk    (clk),
        .resetN (resetN),
        .clear  (pause),
        .load   (frame_close & (emit_good | emit_bad)),
        .tick   (frame_close),
        .active (holdoff_active)
    );
`else
    assign holdoff_active = 1'b0;
`endif

    // Sticky per-frame flag register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flags_reg <= '0;
        end else begin
            flags_reg <= flags_next;
        end
    end

    // Registered single-cycle event outputs, only on an unpaused frame close.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collisionSmileyBorderBottom <= 1'b0;
            collisionSmileyObstacle     <= 1'b0;
            collisionSmileyObstacleGood <= 1'b0;
            collisionSmileyObstacleBad  <= 1'b0;
        end else begin
            collisionSmileyBorderBottom <= frame_close & emit_bottom;
            collisionSmileyObstacle     <= frame_close & (emit_good | emit_bad);
            collisionSmileyObstacleGood <= frame_close & emit_good;
            collisionSmileyObstacleBad  <= frame_close & emit_bad;
        end
    end

endmodule
